xadac_vrequant_unit: RTL and testbench
======================================

// Module: xadac_vrequant_unit
// PURPOSE
//  Downstream stage of the vector MAC unit on the xadac coprocessor path.
//  Takes VectorWidth-bit vectors of signed SumWidth accumulators (vmacc results).
//  Rounds, arithmetic-right-shifts and saturates each lane to a signed ElemWidth value.
//  Packs the lanes into resp_vd through a 2-stage valid/ready pipeline with full backpressure.
// PARAMETERS
//  VectorWidth  256  vector register width in bits (default taken from xadac_pkg)
//  SumWidth     32   accumulator lane width; lane count N = VectorWidth/SumWidth
//  ElemWidth    8    output element width
//  IdWidth      4    transaction id width
// PORTS
//  clk         in   1              clock, all logic on rising edge
//  rst         in   1              synchronous, active-high reset
//  req_valid   in   1              request valid
//  req_ready   out  1              request accepted when req_valid && req_ready
//  req_id      in   IdWidth        transaction id, returned unchanged
//  req_vs1     in   VectorWidth    N signed SumWidth accumulators, lane i = [SumWidth*i +: SumWidth]
//  req_imm     in   32             [4:0] shift amount sh; [5] relu (see CONFIGURATION); rest ignored
//  resp_valid  out  1              response valid
//  resp_ready  in   1              response consumed when resp_valid && resp_ready
//  resp_id     out  IdWidth        id of the response
//  resp_vd     out  VectorWidth    lane i result in [ElemWidth*i +: ElemWidth]; bits >= N*ElemWidth are 0
//  resp_rd     out  32             constant 0
// BEHAVIOUR
//  - Reset: s1_valid=s2_valid=0, resp_valid=0, resp_vd=0, resp_id=0; req_ready=1 in the first cycle after reset.
//  - Stage 1 (S1): per lane t = sext(x) + (sh==0 ? 0 : 1<<(sh-1)), computed at SumWidth+1 bits (no overflow).
//    S1 also registers sh, relu and id.
//  - Stage 2 (S2): y = t >>> sh (arithmetic); saturate to [-2^(ElemWidth-1), 2^(ElemWidth-1)-1].
//    S2 drives resp_vd, resp_id and resp_valid directly from registers.
//  - Latency: exactly 2 cycles from accept to resp_valid when resp_ready is held high; throughput 1 per cycle.
//  - Handshake:
//    - adv2 = !s2_valid || resp_ready.
//    - adv1 = !s1_valid || adv2.
//    - req_ready = adv1, combinational from registered state and resp_ready (no path from req_valid).
//  - Stall: while resp_valid && !resp_ready, resp_vd and resp_id hold stable; S1 holds if occupied.
//  - Full pipe with resp_ready=1: the S2 output retires, S1 moves to S2, and a new request enters S1, all in the same cycle.
//  - Empty pipe, req_valid=0: nothing moves and resp_valid stays 0.
//  - Rounding is round-half-up on the shifted value; -3 with sh=1 gives -1, 3 with sh=1 gives 2.
//  - sh up to 31 is legal; large sh collapses results toward 0 or -1.
//  - Reset asserted mid-operation clears all in-flight entries; no response is emitted for them.
//  - Unused data registers need not be cleared; only the valids and the output registers reset.
// CONFIGURATION
//  - Macro XADAC_VREQUANT_RELU_EN defined: when the registered relu bit is 1, negative saturated lanes output 0
//    (applied in S2 after saturation).
//  - Macro not defined: req_imm[5] is ignored; no relu logic is synthesised.
//  - Latency and handshake are identical in both builds.
// STRUCTURE
//  - xadac_pkg holds VectorWidth, SumWidth, ElemWidth, the derived lane count,
//    and a function sat_s(value, width) returning the signed-saturated value.
//  - One sub-module: xadac_vrequant_lane, combinational per-lane round / shift / saturate / relu, split into S1 and S2 parts.
//    The top instantiates N lanes and owns all pipeline registers and the handshake.
// TESTING
//  1. Single op, sh=4, lane0=0x00000128 (296), resp_ready=1:
//     -> resp_valid exactly 2 cycles after accept; lane0 = 0x13 (19), id echoed.
//  2. Saturation, sh=0: lanes {1000, -1000, 127, -128}
//     -> {0x7F, 0x80, 0x7F, 0x80}; resp_vd bits [255:64] = 0.
//  3. Back-to-back, 8 requests, ids 0..7, resp_ready toggling 1,0,0,1,...
//     -> all 8 responses in order, no loss or duplication; resp_vd stable while stalled.
//     -> req_ready=0 only when both stages are full and resp_ready=0.
//  4. Rounding, sh=1, lanes {3, -3, 1, -1}
//     -> {2, -1, 1, 0}; sh=31, lane 0x7FFFFFFF -> 1.
//  5. With XADAC_VREQUANT_RELU_EN, relu=1, sh=0: lanes {-5, 5}
//     -> {0, 5}. Without the macro, same stimulus -> {0xFB, 5}.
//  6. Two requests in flight, rst pulsed 1 cycle
//     -> resp_valid=0 next cycle, no stale response afterwards; a fresh request completes normally.

Source files
------------

// File: rtl/xadac_pkg.sv
// xadac_pkg: shared widths, lane count and signed saturation helper for the requant unit
package xadac_pkg;
  localparam int VectorWidth = 256;
  localparam int SumWidth = 32;
  localparam int ElemWidth = 8;
  localparam int IdWidth = 4;
  localparam int Lanes = VectorWidth / SumWidth;
  function automatic logic signed [SumWidth:0] sat_s(input logic signed [SumWidth:0] value, input int width);
    logic signed [SumWidth:0] hi, lo;
    hi = ((SumWidth + 1)'(1) <<< (width - 1)) - (SumWidth + 1)'(1);
    lo = ~hi;
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/xadac_vrequant_unit_if.sv
// xadac_vrequant_unit_if: request/response handshake bundle; slave = requant unit, master = issuer
interface xadac_vrequant_unit_if;
  logic req_valid;
  logic req_ready;
  logic [xadac_pkg::IdWidth-1:0] req_id;
  logic [xadac_pkg::VectorWidth-1:0] req_vs1;
  logic [31:0] req_imm;
  logic resp_valid;
  logic resp_ready;
  logic [xadac_pkg::IdWidth-1:0] resp_id;
  logic [xadac_pkg::VectorWidth-1:0] resp_vd;
  logic [31:0] resp_rd;
  modport slave (
    input req_valid, req_id, req_vs1, req_imm, resp_ready,
    output req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );
  modport master (
    output req_valid, req_id, req_vs1, req_imm, resp_ready,
    input req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );
endinterface

// File: rtl/xadac_vrequant_lane.sv
// xadac_vrequant_lane: per-lane combinational requant; S1 adds the rounding bias, S2 shifts/saturates (relu under XADAC_VREQUANT_RELU_EN)
module xadac_vrequant_lane
  import xadac_pkg::*;
(
  input  logic [SumWidth-1:0]     x,
  input  logic [4:0]              sh1,
  output logic signed [SumWidth:0] t,
  input  logic signed [SumWidth:0] t2,
  input  logic [4:0]              sh2,
`ifdef XADAC_VREQUANT_RELU_EN
  input  logic                    relu,
`endif
  output logic [ElemWidth-1:0]    y
);
  logic signed [SumWidth:0] rnd, sat;
  logic unused_sat;
  assign rnd = sh1 == 5'd0 ? '0 : (SumWidth + 1)'(1) <<< (sh1 - 5'd1);
  assign t = $signed({x[SumWidth-1], x}) + rnd;
  assign sat = sat_s(t2 >>> sh2, ElemWidth);
  assign unused_sat = ^sat[SumWidth:ElemWidth];
`ifdef XADAC_VREQUANT_RELU_EN
  assign y = relu && sat[ElemWidth-1] ? '0 : sat[ElemWidth-1:0];
`else
  assign y = sat[ElemWidth-1:0];
`endif
endmodule

// File: rtl/xadac_vrequant_unit.sv
// xadac_vrequant_unit: 2-stage valid/ready requantiser (round, >>> sh, saturate to ElemWidth) over all lanes
//   clk, rst : clock and synchronous active-high reset
//   io       : xadac_vrequant_unit_if.slave (req_* in, resp_* out)
//   optional : XADAC_VREQUANT_RELU_EN enables relu from req_imm[5]
module xadac_vrequant_unit
  import xadac_pkg::*;
(
  input logic clk,
  input logic rst,
  xadac_vrequant_unit_if.slave io
);
  logic adv1, adv2, s1_valid, s2_valid;
  logic [IdWidth-1:0] s1_id;
  logic [4:0] s1_sh;
  logic signed [SumWidth:0] s1_t [Lanes];
  logic signed [SumWidth:0] t_next [Lanes];
  logic [VectorWidth-1:0] vd_next;
  logic unused_imm;
`ifdef XADAC_VREQUANT_RELU_EN
  logic s1_relu;
  assign unused_imm = ^io.req_imm[31:6];
`else
  assign unused_imm = ^io.req_imm[31:5];
`endif
  assign adv2 = !s2_valid || io.resp_ready;
  assign adv1 = !s1_valid || adv2;
  assign io.req_ready = adv1;
  assign io.resp_valid = s2_valid;
  assign io.resp_rd = '0;
  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    xadac_vrequant_lane u_lane (
      .x(io.req_vs1[SumWidth*i +: SumWidth]),
      .sh1(io.req_imm[4:0]),
      .t(t_next[i]),
      .t2(s1_t[i]),
      .sh2(s1_sh),
`ifdef XADAC_VREQUANT_RELU_EN
      .relu(s1_relu),
`endif
      .y(vd_next[ElemWidth*i +: ElemWidth])
    );
  end
  assign vd_next[VectorWidth-1:Lanes*ElemWidth] = '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      io.resp_vd <= '0;
      io.resp_id <= '0;
    end else begin
      if (adv1) s1_valid <= io.req_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        io.resp_vd <= vd_next;
        io.resp_id <= s1_id;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (adv1 && io.req_valid) begin
      s1_id <= io.req_id;
      s1_sh <= io.req_imm[4:0];
      s1_t <= t_next;
`ifdef XADAC_VREQUANT_RELU_EN
      s1_relu <= io.req_imm[5];
`endif
    end
  end
endmodule

// File: tb/tb_xadac_vrequant_unit.sv
// tb_xadac_vrequant_unit: directed self-checking bench for xadac_vrequant_unit
module tb_xadac_vrequant_unit;
  logic clk, rst;
  int checks, errors, tx, rx, occ;
  logic stalled, fire_req, fire_resp;
  logic [255:0] v, prev_vd;
  logic [3:0] prev_id;
  xadac_vrequant_unit_if io ();
  xadac_vrequant_unit dut (.clk(clk), .rst(rst), .io(io.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [3:0] id, input logic [255:0] vs1, input logic [31:0] imm, input logic [255:0] exp);
    io.req_valid = 1'b1;
    io.req_id = id;
    io.req_vs1 = vs1;
    io.req_imm = imm;
    io.resp_ready = 1'b1;
    step();
    io.req_valid = 1'b0;
    chk({tag, "_lat1"}, 256'(io.resp_valid), 256'(0));
    step();
    chk({tag, "_valid"}, 256'(io.resp_valid), 256'(1));
    chk({tag, "_vd"}, io.resp_vd, exp);
    chk({tag, "_id"}, 256'(io.resp_id), 256'(id));
    chk({tag, "_rd"}, 256'(io.resp_rd), 256'(0));
    step();
    chk({tag, "_retire"}, 256'(io.resp_valid), 256'(0));
  endtask
  function automatic logic [255:0] exp_b2b(input int id);
    logic [255:0] r;
    r = '0;
    r[7:0] = 8'(2 * id);
    r[15:8] = 8'(-id);
    return r;
  endfunction
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    io.req_valid = 1'b0;
    io.req_id = '0;
    io.req_vs1 = '0;
    io.req_imm = '0;
    io.resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 256'(io.resp_valid), 256'(0));
    chk("rst_vd", io.resp_vd, 256'(0));
    chk("rst_id", 256'(io.resp_id), 256'(0));
    chk("rst_ready", 256'(io.req_ready), 256'(1));
    step();
    v = '0;
    v[31:0] = 32'h0000_0128;
    do_op("single", 4'd5, v, 32'd4, 256'h13);
    v = '0;
    v[31:0] = 32'd1000;
    v[63:32] = -32'sd1000;
    v[95:64] = 32'd127;
    v[127:96] = -32'sd128;
    do_op("sat", 4'd3, v, 32'd0, 256'h807F_807F);
    v = '0;
    v[31:0] = 32'd3;
    v[63:32] = -32'sd3;
    v[95:64] = 32'd1;
    v[127:96] = -32'sd1;
    do_op("round", 4'd6, v, 32'd1, 256'h0001_FF02);
    v = '0;
    v[31:0] = 32'h7FFF_FFFF;
    v[63:32] = 32'h8000_0000;
    do_op("sh31", 4'd7, v, 32'd31, 256'hFF01);
    v = '0;
    v[31:0] = -32'sd5;
    v[63:32] = 32'd5;
`ifdef XADAC_VREQUANT_RELU_EN
    do_op("relu", 4'd8, v, 32'h20, 256'h0500);
`else
    do_op("relu", 4'd8, v, 32'h20, 256'h05FB);
`endif
    tx = 0;
    rx = 0;
    occ = 0;
    stalled = 1'b0;
    prev_vd = '0;
    prev_id = '0;
    for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      io.resp_ready = (cyc % 3) == 0;
      io.req_valid = tx < 8;
      io.req_id = 4'(tx);
      v = '0;
      v[31:0] = 32'(tx * 32);
      v[63:32] = 32'(-tx * 16);
      io.req_vs1 = v;
      io.req_imm = 32'd4;
      #1;
      chk("b2b_ready", 256'(io.req_ready), 256'(!(occ == 2 && !io.resp_ready)));
      if (stalled) begin
        chk("b2b_hold_vd", io.resp_vd, prev_vd);
        chk("b2b_hold_id", 256'(io.resp_id), 256'(prev_id));
      end
      if (io.resp_valid) begin
        chk("b2b_id", 256'(io.resp_id), 256'(rx));
        chk("b2b_vd", io.resp_vd, exp_b2b(rx));
      end
      fire_req = io.req_valid && io.req_ready;
      fire_resp = io.resp_valid && io.resp_ready;
      stalled = io.resp_valid && !io.resp_ready;
      prev_vd = io.resp_vd;
      prev_id = io.resp_id;
      if (fire_req) tx++;
      if (fire_resp) rx++;
      occ = occ + int'(fire_req) - int'(fire_resp);
      step();
    end
    chk("b2b_count", 256'(rx), 256'(8));
    io.req_valid = 1'b0;
    io.resp_ready = 1'b1;
    step();
    chk("b2b_no_dup", 256'(io.resp_valid), 256'(0));
    step();
    chk("idle_quiet", 256'(io.resp_valid), 256'(0));
    io.resp_ready = 1'b0;
    io.req_valid = 1'b1;
    io.req_id = 4'd1;
    io.req_vs1 = 256'd16;
    io.req_imm = 32'd0;
    step();
    io.req_id = 4'd2;
    step();
    io.req_valid = 1'b0;
    chk("inflight_valid", 256'(io.resp_valid), 256'(1));
    chk("inflight_full", 256'(io.req_ready), 256'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 256'(io.resp_valid), 256'(0));
    chk("midrst_ready", 256'(io.req_ready), 256'(1));
    io.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_stale", 256'(io.resp_valid), 256'(0));
    end
    v = '0;
    v[31:0] = 32'd40;
    do_op("fresh", 4'd9, v, 32'd2, 256'h0A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
